// File: rtl/pio_entrada_dados.sv
// pio_entrada_dados: Avalon-MM input port with synchroniser, per-bit edge capture and maskable level irq.
module pio_entrada_dados #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_q, prev_d, mask_q, mask_d, cap_q, cap_d;
  logic [DATA_WIDTH-1:0] data_in, rise, fall, det, w1c;
  logic [31:0]           readdata_q, readdata_d, rd_mux;
  logic                  wr, rd;
  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    data_in = sync_q[SYNC_STAGES-1];
    prev_d  = data_in;
    rise    = data_in & ~prev_q;
    fall    = ~data_in & prev_q;
    det     = EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : (rise | fall);
    wr      = chipselect & ~write_n;
    rd      = chipselect & ~read_n;
    mask_d  = (wr && address == 2'd1) ? writedata[DATA_WIDTH-1:0] : mask_q;
    w1c     = (wr && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;
    // a fresh edge overrides a same-cycle clear so no event is lost
    cap_d   = (cap_q & ~w1c) | det;
    rd_mux  = '0;
    rd_mux[DATA_WIDTH-1:0] = address == 2'd0 ? data_in :
                             address == 2'd1 ? mask_q  :
                             address == 2'd3 ? cap_q   : '0;
    readdata_d = rd ? rd_mux : readdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '{default: '0};
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end
  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);
endmodule

// File: tb/tb_pio_entrada_dados.sv
// tb_pio_entrada_dados: scoreboard bench for the default 32-bit rising-edge port and an 8-bit any-edge port.
module tb_pio_entrada_dados;
  logic        clk = 0, reset = 1, chipselect = 0, read_n = 1, write_n = 1;
  logic [1:0]  address = 0;
  logic [31:0] writedata = 0, in32 = 0, rd32, rd8;
  logic [7:0]  in8 = 0;
  logic        irq32, irq8;
  int          errs = 0, checks = 0;
  typedef struct { bit sel; string tag; logic [31:0] exp; } rd_t;
  rd_t sb [$];

  pio_entrada_dados u32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .in_port(in32), .readdata(rd32), .irq(irq32));
  pio_entrada_dados #(.DATA_WIDTH(8), .EDGE_TYPE(2)) u8 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read_n(read_n),
    .write_n(write_n), .writedata(writedata), .in_port(in8), .readdata(rd8), .irq(irq8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
    rd_t r;
    @(negedge clk);
    chipselect = 1; read_n = 0; address = a;
    sb.push_back('{sel, tag, exp});
    @(negedge clk);
    chipselect = 0; read_n = 1;
    r = sb.pop_front();
    chk(r.tag, r.sel ? rd8 : rd32, r.exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    chk("rst_rd", rd32, 0);
    chk("rst_irq", {31'b0, irq32}, 0);
    reset = 0;
    // data read path
    in32 = 32'hA5A5_1234;
    idle(3);
    rd(0, 0, 32'hA5A5_1234, "data");
    wr(0, 32'hFFFF_FFFF);
    rd(0, 0, 32'hA5A5_1234, "data_wr_ign");
    rd(0, 3, 32'hA5A5_1234, "cap_data");
    chk("irq_unmasked", {31'b0, irq32}, 0);
    wr(3, 32'hFFFF_FFFF);
    rd(0, 3, 0, "cap_clr");
    in32 = 0;
    idle(4);
    rd(0, 3, 0, "fall_nocap");
    // rising capture and irq timing
    wr(1, 1);
    @(negedge clk) in32 = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("irq_k1", {31'b0, irq32}, 0);
    @(posedge clk); #1;
    chk("irq_k2", {31'b0, irq32}, 1);
    rd(0, 3, 1, "cap_b0");
    wr(3, 1);
    chk("irq_w1c", {31'b0, irq32}, 0);
    in32 = 0;
    idle(4);
    rd(0, 3, 0, "b0_fall");
    // masking
    wr(1, 0);
    in32 = 8;
    idle(4);
    rd(0, 3, 8, "cap_b3");
    chk("irq_masked", {31'b0, irq32}, 0);
    wr(1, 8);
    chk("irq_unmask", {31'b0, irq32}, 1);
    rd(0, 1, 8, "mask_rd");
    wr(3, 4);
    rd(0, 3, 8, "w1c_other");
    wr(3, 8);
    in32 = 0;
    // collision: W1C lands on the edge that sets bit0
    wr(1, 1);
    in32 = 1;
    idle(4);
    chk("coll_pre", {31'b0, irq32}, 1);
    in32 = 0;
    idle(4);
    @(negedge clk) in32 = 1;
    @(negedge clk);
    wr(3, 1);
    chk("coll_irq", {31'b0, irq32}, 1);
    rd(0, 3, 1, "coll_cap");
    wr(3, 1);
    chk("coll_clr", {31'b0, irq32}, 0);
    // any-edge capture on the 8-bit instance
    @(negedge clk) in8 = 8'h80;
    idle(3);
    rd(1, 3, 32'h80, "w8_rise");
    rd(1, 0, 32'h80, "w8_data");
    wr(3, 32'h80);
    rd(1, 3, 0, "w8_clr");
    in8 = 0;
    idle(3);
    rd(1, 3, 32'h80, "w8_fall");
    rd(1, 2, 0, "w8_rsvd");
    rd(0, 2, 0, "rsvd");
    // asynchronous reset mid-sim
    in32 = 0;
    idle(3);
    wr(3, 32'hFFFF_FFFF);
    wr(1, 32'hFF);
    in32 = 32'hFF;
    idle(4);
    rd(0, 3, 32'hFF, "pre_rst_cap");
    chk("pre_rst_irq", {31'b0, irq32}, 1);
    in32 = 0;
    idle(3);
    #2 reset = 1;
    #1;
    chk("arst_rd", rd32, 0);
    chk("arst_irq", {31'b0, irq32}, 0);
    idle(2);
    reset = 0;
    rd(0, 1, 0, "post_rst_mask");
    rd(0, 3, 0, "post_rst_cap");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
